// File: rtl/vga_tile_renderer_if.sv
// ----------------------------------------------------------------------------
// vga_tile_renderer_if
// Game-side bus of the tile renderer. The renderer (master) names a game-field
// tile and announces frame/busy status; the game logic (slave) answers with
// the attributes of that tile and the current game state.
//
//   o_request_x   renderer -> game   game-field tile column
//   o_request_y   renderer -> game   game-field tile row
//   o_buzy        renderer -> game   high during active vertical lines
//   o_frame_start renderer -> game   one-cycle pulse per frame
//   i_state       game -> renderer   bit0 checker phase, bit1 pause-dim
//   i_is_*        game -> renderer   attributes of the requested tile
// ----------------------------------------------------------------------------
interface vga_tile_renderer_if #(
    parameter int X_W = 6,
    parameter int Y_W = 6
) ();
    logic [X_W-1:0] o_request_x;
    logic [Y_W-1:0] o_request_y;
    logic           o_buzy;
    logic           o_frame_start;
    logic [1:0]     i_state;
    logic           i_is_wall;
    logic           i_is_tank_1;
    logic           i_is_tank_2;
    logic           i_is_shell_1;
    logic           i_is_shell_2;

    modport master (
        output o_request_x, o_request_y, o_buzy, o_frame_start,
        input  i_state, i_is_wall, i_is_tank_1, i_is_tank_2,
               i_is_shell_1, i_is_shell_2
    );

    modport slave (
        input  o_request_x, o_request_y, o_buzy, o_frame_start,
        output i_state, i_is_wall, i_is_tank_1, i_is_tank_2,
               i_is_shell_1, i_is_shell_2
    );
endinterface

// File: rtl/vga_tile_renderer.sv
// ----------------------------------------------------------------------------
// vga_tile_renderer
// Generates VGA timing, walks the visible area as a grid of TILE_PX x TILE_PX
// tiles, asks the game logic for the attributes of each tile GAME_LAT cycles
// ahead of use, and composes the final pixel colour by layer priority over a
// checkerboard, with a status bar across the top BAR_ROWS tile rows.
//
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   VGA_R/G/B             8-bit colour channels (zero outside active area)
//   VGA_HS, VGA_VS        active-low syncs, aligned with the colour
//   VGA_BLANK_N           high on active pixels, aligned with the colour
//   VGA_SYNC_N            constant 0
//   VGA_CLK               copy of clk
//   game                  request / attribute bus to the game logic
// ----------------------------------------------------------------------------
module vga_tile_renderer #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_DISP   = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_DISP   = 480,
    parameter int V_FRONT  = 10,
    parameter int TILE_PX  = 10,
    parameter int BAR_ROWS = 4,
    parameter int GAME_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK,
    vga_tile_renderer_if.master game
);

    localparam int H_TOTAL   = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL   = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_W       = $clog2(H_TOTAL);
    localparam int V_W       = $clog2(V_TOTAL);
    localparam int H_START   = H_SYNC + H_BACK;
    localparam int V_START   = V_SYNC + V_BACK;
    localparam int TILES_X   = H_DISP / TILE_PX;
    localparam int TILES_Y   = V_DISP / TILE_PX;
    localparam int GAME_ROWS = TILES_Y - BAR_ROWS;
    localparam int TX_W      = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int TY_W      = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
    localparam int RY_W      = (GAME_ROWS > 1) ? $clog2(GAME_ROWS) : 1;
    localparam int SUB_W     = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;

    localparam logic [H_W-1:0]   H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0]   H_SYNC_C  = H_W'(H_SYNC);
    localparam logic [V_W-1:0]   V_SYNC_C  = V_W'(V_SYNC);
    localparam logic [H_W-1:0]   H_START_C = H_W'(H_START);
    localparam logic [H_W-1:0]   H_END_C   = H_W'(H_START + H_DISP);
    localparam logic [V_W-1:0]   V_START_C = V_W'(V_START);
    localparam logic [V_W-1:0]   V_END_C   = V_W'(V_START + V_DISP);
    localparam logic [H_W-1:0]   H_PRE_C   = H_W'(H_START - 1);
    localparam logic [V_W-1:0]   V_PRE_C   = V_W'(V_START - 1);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(TILE_PX - 1);
    localparam logic [TY_W-1:0]  BAR_C     = TY_W'(BAR_ROWS);

    localparam logic [23:0] COL_BAR     = 24'h7F7F7F;
    localparam logic [23:0] COL_SHELL_1 = 24'hFF4040;
    localparam logic [23:0] COL_SHELL_2 = 24'h4040FF;
    localparam logic [23:0] COL_TANK_1  = 24'hC00000;
    localparam logic [23:0] COL_TANK_2  = 24'h0000C0;
    localparam logic [23:0] COL_WALL    = 24'h404040;
    localparam logic [23:0] COL_CHK_ODD = 24'h6699FF;
    localparam logic [23:0] COL_CHK_EVN = 24'hFFFF66;

    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;
    logic [SUB_W-1:0] sub_x, sub_y;
    logic [TX_W-1:0]  tile_x;
    logic [TY_W-1:0]  tile_y;
    logic [1:0]       state_q;

    logic h_act, v_act, pix_act;

    // Stage-0 attributes of the pixel currently at the counters, delayed so
    // that index GAME_LAT lines up with the returning tile attributes.
    logic [GAME_LAT:0] act_d, hs_d, vs_d, bar_d, par_d;

    logic [23:0] pix_col;
    logic [23:0] chk_col;

    assign VGA_SYNC_N = 1'b0;
    assign VGA_CLK    = clk;

    assign h_act   = (h_cnt >= H_START_C) && (h_cnt < H_END_C);
    assign v_act   = (v_cnt >= V_START_C) && (v_cnt < V_END_C);
    assign pix_act = h_act && v_act;

    function automatic logic [23:0] halve(input logic [23:0] c);
        return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
    endfunction

    // Raster counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Tile position by counting: cleared one cycle ahead of the first active
    // column/line so they already read zero on the first active pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_x  <= '0;
            tile_x <= '0;
            sub_y  <= '0;
            tile_y <= '0;
        end else begin
            if (h_cnt == H_PRE_C) begin
                sub_x  <= '0;
                tile_x <= '0;
            end else if (h_act) begin
                if (sub_x == SUB_LAST) begin
                    sub_x  <= '0;
                    tile_x <= tile_x + 1'b1;
                end else begin
                    sub_x <= sub_x + 1'b1;
                end
            end
            if (h_cnt == H_LAST) begin
                if (v_cnt == V_PRE_C) begin
                    sub_y  <= '0;
                    tile_y <= '0;
                end else if (v_act) begin
                    if (sub_y == SUB_LAST) begin
                        sub_y  <= '0;
                        tile_y <= tile_y + 1'b1;
                    end else begin
                        sub_y <= sub_y + 1'b1;
                    end
                end
            end
        end
    end

    // Request bus, frame status and the per-frame game-state snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            game.o_request_x   <= '0;
            game.o_request_y   <= '0;
            game.o_buzy        <= 1'b0;
            game.o_frame_start <= 1'b0;
            state_q            <= 2'b00;
        end else begin
            if (pix_act) begin
                game.o_request_x <= tile_x;
            end
            game.o_request_y   <= (tile_y >= BAR_C) ? RY_W'(tile_y - BAR_C) : '0;
            game.o_buzy        <= v_act;
            game.o_frame_start <= (h_cnt == '0) && (v_cnt == '0);
            if ((h_cnt == '0) && (v_cnt == '0)) begin
                state_q <= game.i_state;
            end
        end
    end

    // Delay line keeping syncs, blanking and tile facts aligned with the
    // attributes that come back GAME_LAT cycles after the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_d <= '0;
            hs_d  <= '0;
            vs_d  <= '0;
            bar_d <= '0;
            par_d <= '0;
        end else begin
            act_d <= {act_d[GAME_LAT-1:0], pix_act};
            hs_d  <= {hs_d[GAME_LAT-1:0], (h_cnt >= H_SYNC_C)};
            vs_d  <= {vs_d[GAME_LAT-1:0], (v_cnt >= V_SYNC_C)};
            bar_d <= {bar_d[GAME_LAT-1:0], (tile_y < BAR_C)};
            par_d <= {par_d[GAME_LAT-1:0], tile_x[0] ^ tile_y[0]};
        end
    end

    // Layer priority; only the checkerboard and walls respond to pause-dim.
    always_comb begin
        chk_col = (par_d[GAME_LAT] ^ state_q[0]) ? COL_CHK_ODD : COL_CHK_EVN;
        pix_col = state_q[1] ? halve(chk_col) : chk_col;
        if (bar_d[GAME_LAT]) begin
            pix_col = COL_BAR;
        end else if (game.i_is_shell_1) begin
            pix_col = COL_SHELL_1;
        end else if (game.i_is_shell_2) begin
            pix_col = COL_SHELL_2;
        end else if (game.i_is_tank_1) begin
            pix_col = COL_TANK_1;
        end else if (game.i_is_tank_2) begin
            pix_col = COL_TANK_2;
        end else if (game.i_is_wall) begin
            pix_col = state_q[1] ? halve(COL_WALL) : COL_WALL;
        end
        if (!act_d[GAME_LAT]) begin
            pix_col = 24'h000000;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
            VGA_HS      <= 1'b0;
            VGA_VS      <= 1'b0;
            VGA_BLANK_N <= 1'b0;
        end else begin
            VGA_R       <= pix_col[23:16];
            VGA_G       <= pix_col[15:8];
            VGA_B       <= pix_col[7:0];
            VGA_HS      <= hs_d[GAME_LAT];
            VGA_VS      <= vs_d[GAME_LAT];
            VGA_BLANK_N <= act_d[GAME_LAT];
        end
    end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// ----------------------------------------------------------------------------
// tb_vga_tile_renderer
// Drives a reduced-size raster through the renderer with a random tile map and
// random game-state changes, answering tile requests with a GAME_LAT-cycle
// game model, and compares every output against a pixel-index reference.
// ----------------------------------------------------------------------------
module tb_vga_tile_renderer;

    localparam int HSY = 4, HBK = 3, HDI = 40, HFR = 3;
    localparam int VSY = 2, VBK = 3, VDI = 30, VFR = 2;
    localparam int TP = 5, BAR = 1, LAT = 2;
    localparam int HT = HSY + HBK + HDI + HFR;
    localparam int VT = VSY + VBK + VDI + VFR;
    localparam int FRAME = HT * VT;
    localparam int HST = HSY + HBK;
    localparam int VST = VSY + VBK;
    localparam int COLS = HDI / TP;
    localparam int GROWS = VDI / TP - BAR;
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(GROWS);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;

    always #5 clk = ~clk;

    vga_tile_renderer_if #(.X_W(XW), .Y_W(YW)) game_if ();

    vga_tile_renderer #(
        .H_SYNC(HSY), .H_BACK(HBK), .H_DISP(HDI), .H_FRONT(HFR),
        .V_SYNC(VSY), .V_BACK(VBK), .V_DISP(VDI), .V_FRONT(VFR),
        .TILE_PX(TP), .BAR_ROWS(BAR), .GAME_LAT(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .VGA_R(vga_r),
        .VGA_G(vga_g),
        .VGA_B(vga_b),
        .VGA_HS(vga_hs),
        .VGA_VS(vga_vs),
        .VGA_BLANK_N(vga_blank_n),
        .VGA_SYNC_N(vga_sync_n),
        .VGA_CLK(vga_clk),
        .game(game_if.master)
    );

    int checks = 0;
    int errors = 0;
    int k = 0;
    bit seen_active = 0;
    logic [4:0] tile_map [0:GROWS-1][0:COLS-1];
    int frame_state [0:63];
    int hist_x [0:3];
    int hist_y [0:3];

    // Attribute bits: 0 wall, 1 tank_1, 2 tank_2, 3 shell_1, 4 shell_2.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30)
                $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    function automatic int hOf(int p);
        return p % HT;
    endfunction

    function automatic int vOf(int p);
        return (p / HT) % VT;
    endfunction

    function automatic bit vActive(int p);
        return (vOf(p) >= VST) && (vOf(p) < VST + VDI);
    endfunction

    function automatic bit isActive(int p);
        return vActive(p) && (hOf(p) >= HST) && (hOf(p) < HST + HDI);
    endfunction

    function automatic logic [23:0] dimmed(logic [23:0] c);
        int r = int'(c[23:16]) / 2;
        int g = int'(c[15:8]) / 2;
        int b = int'(c[7:0]) / 2;
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    function automatic logic [23:0] expColour(int p);
        int tx, ty, f;
        logic [1:0] st;
        logic [4:0] a;
        logic [23:0] chk;
        if (!isActive(p)) return 24'h000000;
        tx = (hOf(p) - HST) / TP;
        ty = (vOf(p) - VST) / TP;
        f  = p / FRAME;
        st = (f < 64) ? 2'(frame_state[f]) : 2'b00;
        if (ty < BAR) return 24'h7F7F7F;
        a = tile_map[ty - BAR][tx];
        if (a[3]) return 24'hFF4040;
        if (a[4]) return 24'h4040FF;
        if (a[1]) return 24'hC00000;
        if (a[2]) return 24'h0000C0;
        if (a[0]) return st[1] ? dimmed(24'h404040) : 24'h404040;
        chk = (((tx + ty + int'(st[0])) % 2) == 1) ? 24'h6699FF : 24'hFFFF66;
        return st[1] ? dimmed(chk) : chk;
    endfunction

    task automatic regenMap();
        for (int y = 0; y < GROWS; y++)
            for (int x = 0; x < COLS; x++)
                for (int b = 0; b < 5; b++)
                    tile_map[y][x][b] = ($urandom_range(0, 3) == 0);
        tile_map[2][3] = 5'b11111;
        tile_map[3][5] = 5'b00001;
        tile_map[1][6] = 5'b01100;
        tile_map[0][0] = 5'b00000;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_rgb", {8'h00, vga_r, vga_g, vga_b}, 32'h0);
        checkOutput("rst_hs", {31'h0, vga_hs}, 32'h0);
        checkOutput("rst_vs", {31'h0, vga_vs}, 32'h0);
        checkOutput("rst_blank_n", {31'h0, vga_blank_n}, 32'h0);
        checkOutput("rst_req_x", 32'(game_if.o_request_x), 32'h0);
        checkOutput("rst_req_y", 32'(game_if.o_request_y), 32'h0);
        checkOutput("rst_buzy", {31'h0, game_if.o_buzy}, 32'h0);
        checkOutput("rst_frame_start", {31'h0, game_if.o_frame_start}, 32'h0);
    endtask

    // Compares all outputs visible in cycle k with the reference.
    task automatic checkCycle();
        int p = k - 2 - LAT;
        int q = k - 1;
        int ty;
        bit e_hs = 0, e_vs = 0, e_bl = 0;
        logic [23:0] e_rgb = 24'h0;
        if (p >= 0) begin
            e_rgb = expColour(p);
            e_hs  = (hOf(p) >= HSY);
            e_vs  = (vOf(p) >= VSY);
            e_bl  = isActive(p);
        end
        checkOutput("rgb", {8'h00, vga_r, vga_g, vga_b}, {8'h00, e_rgb});
        checkOutput("hs", {31'h0, vga_hs}, {31'h0, e_hs});
        checkOutput("vs", {31'h0, vga_vs}, {31'h0, e_vs});
        checkOutput("blank_n", {31'h0, vga_blank_n}, {31'h0, e_bl});
        checkOutput("frame_start", {31'h0, game_if.o_frame_start},
                    {31'h0, (q >= 0) && (q % FRAME == 0)});
        checkOutput("buzy", {31'h0, game_if.o_buzy}, {31'h0, (q >= 0) && vActive(q)});
        if (q >= 0) begin
            if (isActive(q)) begin
                ty = (vOf(q) - VST) / TP;
                checkOutput("req_x", 32'(game_if.o_request_x), 32'((hOf(q) - HST) / TP));
                checkOutput("req_y", 32'(game_if.o_request_y), 32'((ty >= BAR) ? ty - BAR : 0));
                seen_active = 1;
            end else begin
                checkOutput("req_x_hold", 32'(game_if.o_request_x),
                            seen_active ? 32'(COLS - 1) : 32'h0);
            end
        end
    endtask

    // Game model: answers each request LAT cycles later, occasionally changes
    // the game state mid-frame, and records the state the frame will use.
    task automatic applyStimulus();
        int rx, ry;
        logic [4:0] a;
        for (int i = 3; i > 0; i--) begin
            hist_x[i] = hist_x[i-1];
            hist_y[i] = hist_y[i-1];
        end
        hist_x[0] = int'(game_if.o_request_x);
        hist_y[0] = int'(game_if.o_request_y);
        if (k % FRAME == FRAME / 2)
            game_if.i_state = game_if.i_state ^ 2'b01;
        if ($urandom_range(0, 499) == 0)
            game_if.i_state = 2'($urandom_range(0, 3));
        if (k % FRAME == 0) begin
            regenMap();
            if (k / FRAME < 64) frame_state[k / FRAME] = int'(game_if.i_state);
        end
        rx = hist_x[LAT];
        ry = hist_y[LAT];
        a  = (rx < COLS && ry < GROWS) ? tile_map[ry][rx] : 5'b00000;
        game_if.i_is_wall    = a[0];
        game_if.i_is_tank_1  = a[1];
        game_if.i_is_tank_2  = a[2];
        game_if.i_is_shell_1 = a[3];
        game_if.i_is_shell_2 = a[4];
    endtask

    task automatic runEpoch(input int cycles);
        k = 0;
        seen_active = 0;
        for (int i = 0; i < 4; i++) begin
            hist_x[i] = 0;
            hist_y[i] = 0;
        end
        rst_n = 1'b1;
        #0;
        repeat (cycles) begin
            checkCycle();
            applyStimulus();
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        game_if.i_state      = 2'b00;
        game_if.i_is_wall    = 1'b0;
        game_if.i_is_tank_1  = 1'b0;
        game_if.i_is_tank_2  = 1'b0;
        game_if.i_is_shell_1 = 1'b0;
        game_if.i_is_shell_2 = 1'b0;
        regenMap();
        repeat (3) begin
            @(negedge clk);
            checkResetOutputs();
        end
        checkOutput("sync_n", {31'h0, vga_sync_n}, 32'h0);
        checkOutput("vga_clk_low", {31'h0, vga_clk}, 32'h0);
        #5;
        checkOutput("vga_clk_high", {31'h0, vga_clk}, 32'h1);
        @(negedge clk);

        $display("[TB] first run, %0d frames", 3);
        runEpoch(3 * FRAME + 777);

        $display("[TB] reset pulsed mid-line");
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        repeat (3) begin
            @(negedge clk);
            checkResetOutputs();
        end

        game_if.i_state = 2'b10;
        runEpoch(3 * FRAME + 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
